// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// The LOADER_CHECKSUM_EN build uses StChk; otherwise that encoding is never entered.
package prog_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  W_EN_FULL  = 4'b1111;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StWrite,
    StChk,
    StDone
  } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and SRAM write port of the program loader.
// The master side is the loader itself; the slave side is the byte source plus SRAM.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 16
) ();

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_w_en;
  logic [31:0]       mem_write_data;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_addr,
    output mem_w_en,
    output mem_write_data
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_addr,
    input  mem_w_en,
    input  mem_write_data
  );

endinterface

// File: rtl/loader_word_asm.sv
// Little-endian byte-to-word assembler: byte 0 lands in bits [7:0].
// word_o already includes the byte being accepted, so word_full_o and word_o line up.
module loader_word_asm
  import prog_loader_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    byte_valid_i,
  input  logic [7:0]              byte_i,
  output logic [8*WORD_BYTES-1:0] word_o,
  output logic                    word_full_o
);

  localparam int unsigned IdxW = $clog2(WORD_BYTES);

  logic [IdxW-1:0]         idx_q, idx_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clr_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (byte_valid_i) begin
      word_d[8*idx_q +: 8] = byte_i;
      idx_d                = idx_q + IdxW'(1);
    end
  end

  assign word_o      = word_d;
  assign word_full_o = byte_valid_i && !clr_i && (idx_q == IdxW'(WORD_BYTES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: length-prefixed little-endian byte stream -> 32-bit SRAM word writes.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte and report error.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  prog_loader_if.master bus,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          error
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e StLoadEnd = StChk;
`else
  localparam state_e StLoadEnd = StDone;
`endif

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_w_en_q, mem_w_en_d;
  logic [31:0]       mem_write_data_q, mem_write_data_d;
  logic              accept, load_start, word_full, err;
  logic [31:0]       word;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
  logic       error_q, error_d;
  assign err = error_q;
`else
  assign err = 1'b0;
`endif

  assign accept     = bus.in_valid && bus.in_ready;
  assign load_start = start && (state_q inside {StIdle, StDone});

  loader_word_asm u_word_asm (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (load_start),
    .byte_valid_i(accept && (state_q == StData)),
    .byte_i      (bus.in_data),
    .word_o      (word),
    .word_full_o (word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      count_q          <= '0;
      mem_addr_q       <= BASE_ADDR;
      mem_w_en_q       <= '0;
      mem_write_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q            <= '0;
      error_q          <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      mem_addr_q       <= mem_addr_d;
      mem_w_en_q       <= mem_w_en_d;
      mem_write_data_q <= mem_write_data_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q            <= xor_d;
      error_q          <= error_d;
`endif
    end
  end

  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    mem_addr_d       = mem_addr_q;
    mem_w_en_d       = '0;
    mem_write_data_d = mem_write_data_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d   = xor_q;
    error_d = error_q;
    if (load_start) begin
      xor_d   = '0;
      error_d = 1'b0;
    end else if (accept && (state_q != StChk)) begin
      xor_d = xor_q ^ bus.in_data;
    end
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StLenLo;
          mem_addr_d = BASE_ADDR;
        end
      end
      StLenLo: begin
        if (accept) begin
          count_d[7:0] = bus.in_data;
          state_d      = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          count_d[15:8] = bus.in_data;
          state_d       = (count_d == '0) ? StLoadEnd : StData;
        end
      end
      StData: begin
        // Write strobe and data are registered on the 4th accept, so they line up with StWrite.
        if (word_full) begin
          state_d          = StWrite;
          mem_w_en_d       = W_EN_FULL;
          mem_write_data_d = word;
        end
      end
      StWrite: begin
        mem_addr_d = mem_addr_q + ADDR_W'(4);
        count_d    = count_q - 16'd1;
        state_d    = (count_d == '0) ? StLoadEnd : StData;
      end
`ifdef LOADER_CHECKSUM_EN
      StChk: begin
        if (accept) begin
          error_d = (bus.in_data != xor_q);
          state_d = StDone;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      StLenLo, StLenHi, StData, StChk: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
      end
      StWrite: busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
    cpu_rst = !(done && !err);
    error   = err;
  end

  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_w_en       = mem_w_en_q;
  assign bus.mem_write_data = mem_write_data_q;

endmodule
